fir_param: RTL and testbench
============================

// Module: fir_param
// PURPOSE
//  Parametrised direct-form FIR filter; successor to the fixed 17-tap 8-bit filter.
//  - Taps, data width and coefficient width are generics.
//  - Coefficients are runtime-loadable through a write port.
//  - The delay line advances only on valid input; output is qualified by valid_o.
//  - Rounded, scaled output. Sits between the sample source and the downstream DSP chain.
// PARAMETERS
//  TAPS       17  number of taps, 2..64
//  DATA_W      8  signed input/output sample width
//  COEF_W     16  signed coefficient width
//  FRAC_BITS  14  coefficient fraction bits; output = sum >>> FRAC_BITS
//  ACC_W      DATA_W+COEF_W+$clog2(TAPS)  accumulator width (localparam)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-high reset
//  data_i     in   DATA_W     signed input sample
//  valid_i    in   1          data_i valid this cycle
//  flush_i    in   1          clear delay line (synchronous)
//  coef_we    in   1          coefficient write strobe
//  coef_addr  in   $clog2(TAPS)  tap index to write
//  coef_data  in   COEF_W     signed coefficient value
//  data_o     out  DATA_W     signed filtered sample
//  valid_o    out  1          data_o valid (one pulse per accepted input)
// BEHAVIOUR
//  Reset (async, rst=1):
//  - delay line, coefficients, pipeline regs, data_o=0, valid_o=0.
//  Delay line x[0..TAPS-1] (cycle k = edge where valid_i=1 is sampled):
//  - valid_i=1 at edge: x[0]<=data_i, x[i]<=x[i-1].
//  - valid_i=0: hold; no shift.
//  Pipeline, fixed latency 3 (data_o/valid_o updated at edge k+3):
//  - S1 (edge k+1): p[i] <= x[i]*h[i], signed, full DATA_W+COEF_W width.
//  - S2 (edge k+2): acc <= sign-extended sum of all p[i], ACC_W bits; no overflow possible.
//  - S3 (edge k+3): r = acc + (FRAC_BITS>0 ? 2**(FRAC_BITS-1) : 0).
//      Output is r >>> FRAC_BITS, reduced to DATA_W (round half toward +inf).
//  valid pipeline:
//  - v1..v3 shift register; valid_o=v3. Back-to-back valid_i gives back-to-back valid_o.
//  - valid_o=0: data_o holds its last value.
//  Coefficient port:
//  - coef_we=1: h[coef_addr] <= coef_data at the edge.
//  - coef_addr >= TAPS: write ignored.
//  - New value is used by S1 from the next edge.
//  - Writes mid-stream are legal. Samples already past S1 keep their old products.
//  flush_i=1:
//  - x[1..TAPS-1] <= 0.
//  - x[0] <= valid_i ? data_i : 0 (the simultaneous input is kept).
//  - Pipeline stages and valid bits are NOT cleared; in-flight results complete.
//  Reset mid-operation:
//  - all in-flight results are discarded; valid_o=0 immediately (async).
//  Coefficients are not retained across rst; they must be reloaded.
// CONFIGURATION
//  FIR_SATURATE_EN defined:
//  - S3 clamps the shifted result to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
//  - Overflow is sticky: sat_o (out, 1) goes high and clears only on rst.
//  FIR_SATURATE_EN undefined:
//  - S3 takes the low DATA_W bits of the shifted result (two's-complement wrap).
//  - sat_o port is absent.
// TESTING
//  1 Impulse: TAPS=4, FRAC_BITS=0, h={1,2,3,4}; valid stream 1,0,0,0,0
//    -> valid_o stream 1,2,3,4,0, first valid_o 3 cycles after first valid_i.
//  2 Gapped valid: same setup, valid_i every 3rd cycle
//    -> identical output sequence; valid_o pulses exactly 3 cycles after each valid_i.
//  3 Rounding: TAPS=17, FRAC_BITS=14, h[0]=0x2000 (0.5), other taps 0;
//    inputs 3, -3 -> outputs 2, -1.
//  4 Saturation: TAPS=17, all h=0x4000, 17 inputs of 127
//    -> with macro: data_o=127, sat_o=1.
//    -> without macro: data_o = low 8 bits of 2159 = 0x6F (111).
//  5 Flush/coef: with delay line full of 10, assert flush_i with valid_i=1, data_i=5,
//    and write h[0]=0x4000 in the same cycle
//    -> next output uses only 5*h[0] for x[0]; in-flight results unchanged.
//  6 Reset mid-stream: assert rst between valid_i and valid_o
//    -> valid_o and data_o = 0 immediately; no valid_o after release
//       until a new valid_i is accepted.

Source files
------------

// File: rtl/fir_param.sv
// fir_param -- parametrised direct-form FIR filter with runtime-loadable taps.
//
// A delay line of TAPS signed samples advances on every accepted input.
// A three-stage pipeline multiplies, sums and then rounds/scales each
// accepted sample's window. The result appears on data_o, qualified by
// valid_o, exactly three edges after the sample was accepted.
//
// Build option:
//   FIR_SATURATE_EN  When defined, the scaled result is clamped to the
//                    DATA_W range, and the sticky sat_o output flags any
//                    clamping. When undefined, the result wraps
//                    (two's complement) and sat_o does not exist.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   data_i     signed input sample
//   valid_i    data_i is valid this cycle
//   flush_i    synchronous clear of the delay line
//   coef_we    coefficient write strobe
//   coef_addr  tap index to write (indices >= TAPS are ignored)
//   coef_data  signed coefficient value
//   data_o     signed filtered sample, held while valid_o is low
//   valid_o    one pulse per accepted input
//   sat_o      sticky overflow flag (FIR_SATURATE_EN builds only)

module fir_param #(
    parameter int TAPS      = 17,
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   data_i,
    input  logic                       valid_i,
    input  logic                       flush_i,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic signed [DATA_W-1:0]   data_o,
    output logic                       valid_o
`ifdef FIR_SATURATE_EN
    ,
    output logic                       sat_o
`endif
);

    localparam int ADDR_W    = $clog2(TAPS);
    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int ACC_W     = PROD_W + $clog2(TAPS);
    // One spare bit so adding the rounding constant can never overflow.
    localparam int RND_W     = ACC_W + 1;
    localparam int RND_SHIFT = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [RND_W-1:0] ROUND_C =
        (FRAC_BITS > 0) ? (RND_W'(1) << RND_SHIFT) : '0;
`ifdef FIR_SATURATE_EN
    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [DATA_W-1:0] x_d [TAPS];
    logic signed [COEF_W-1:0] h_q [TAPS];
    logic signed [PROD_W-1:0] p_q [TAPS];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [RND_W-1:0]  rounded;
    logic signed [DATA_W-1:0] data_q;
    logic signed [DATA_W-1:0] data_d;
    logic                     accepted_q;
    logic                     v1_q;
    logic                     v2_q;
    logic                     v3_q;
`ifdef FIR_SATURATE_EN
    logic signed [RND_W-1:0]  shifted;
    logic                     overflow;
    logic                     sat_q;
`endif

    // Delay-line next state. A flush zeroes the whole line but still keeps
    // a sample arriving in the same cycle, so it lands in x[0].
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            x_d[i] = x_q[i];
        end
        if (flush_i) begin
            for (int i = 0; i < TAPS; i++) begin
                x_d[i] = '0;
            end
            if (valid_i) begin
                x_d[0] = data_i;
            end
        end else if (valid_i) begin
            x_d[0] = data_i;
            for (int i = 1; i < TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    // Coefficient bank. Comparing against each tap index means an address
    // beyond the last tap simply matches nothing and the write is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                h_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (coef_we && (coef_addr == ADDR_W'(i))) begin
                    h_q[i] <= coef_data;
                end
            end
        end
    end

    // Valid tracking: accepted_q marks a sample that entered the line on the
    // previous edge; v1..v3 follow it through multiply, sum and scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted_q <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
        end else begin
            accepted_q <= valid_i;
            v1_q       <= accepted_q;
            v2_q       <= v1_q;
            v3_q       <= v2_q;
        end
    end

    // Stage 1: full-precision products. The coefficients are sampled here,
    // so a write lands on samples that have not yet reached this stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                p_q[i] <= '0;
            end
        end else if (accepted_q) begin
            for (int i = 0; i < TAPS; i++) begin
                p_q[i] <= PROD_W'(x_q[i]) * PROD_W'(h_q[i]);
            end
        end
    end

    // Stage 2: adder tree. The accumulator's clog2(TAPS) guard bits absorb
    // the growth of the sum, so it never overflows.
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < TAPS; i++) begin
            acc_d = acc_d + ACC_W'(p_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (v1_q) begin
            acc_q <= acc_d;
        end
    end

    // Stage 3: round half toward +inf, then drop the fraction bits.
    always_comb begin
        rounded = RND_W'(acc_q) + ROUND_C;
`ifdef FIR_SATURATE_EN
        shifted  = rounded >>> FRAC_BITS;
        overflow = 1'b0;
        data_d   = DATA_W'(shifted);
        if (shifted > SAT_MAX) begin
            data_d   = DATA_W'(SAT_MAX);
            overflow = 1'b1;
        end else if (shifted < SAT_MIN) begin
            data_d   = DATA_W'(SAT_MIN);
            overflow = 1'b1;
        end
`else
        data_d = DATA_W'(rounded >>> FRAC_BITS);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (v2_q) begin
            data_q <= data_d;
        end
    end

`ifdef FIR_SATURATE_EN
    // Sticky overflow flag. Only a reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (v2_q && overflow) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_o = sat_q;
`endif

    assign data_o  = data_q;
    assign valid_o = v3_q;

endmodule

// File: tb/tb_fir_param.sv
// tb_fir_param -- directed bench for fir_param.
// Instance A is a 4-tap integer filter (FRAC_BITS=0). It exercises the
// impulse, gapped-valid and reset cases. Instance B is the default 17-tap
// Q14 filter. It exercises rounding, overflow, flush and coefficient timing.

module tb_fir_param;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic               aValid, aFlush, aWe, aValidO;
    logic signed [7:0]  aData, aOut;
    logic [1:0]         aAddr;
    logic signed [15:0] aCoef;

    logic               bValid, bFlush, bWe, bValidO;
    logic signed [7:0]  bData, bOut;
    logic [4:0]         bAddr;
    logic signed [15:0] bCoef;

`ifdef FIR_SATURATE_EN
    logic aSat, bSat;
`endif

    fir_param #(.TAPS(4), .DATA_W(8), .COEF_W(16), .FRAC_BITS(0)) dutA (
        .clk(clk), .rst(rst), .data_i(aData), .valid_i(aValid), .flush_i(aFlush),
        .coef_we(aWe), .coef_addr(aAddr), .coef_data(aCoef),
        .data_o(aOut), .valid_o(aValidO)
`ifdef FIR_SATURATE_EN
        , .sat_o(aSat)
`endif
    );

    fir_param #(.TAPS(17), .DATA_W(8), .COEF_W(16), .FRAC_BITS(14)) dutB (
        .clk(clk), .rst(rst), .data_i(bData), .valid_i(bValid), .flush_i(bFlush),
        .coef_we(bWe), .coef_addr(bAddr), .coef_data(bCoef),
        .data_o(bOut), .valid_o(bValidO)
`ifdef FIR_SATURATE_EN
        , .sat_o(bSat)
`endif
    );

    typedef struct {
        bit valid;
        int data;
        bit expValid;
        int expData;
    } vec_t;

    vec_t tbl[32];
    int   vecCount  = 0;
    int   missCount = 0;

    // One comparison: counts it and reports it on a mismatch.
    task automatic checkOutput(input string name, input integer actual, input integer expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs on the selected instance (sel=0 -> A, 1 -> B).
    // The other instance idles. Returns 1ns after the rising edge.
    task automatic applyStimulus(input bit sel, input bit valid, input int data, input bit flush,
                                 input bit we, input int addr, input int coef);
        @(negedge clk);
        aValid = 1'b0; aData = '0; aFlush = 1'b0; aWe = 1'b0; aAddr = '0; aCoef = '0;
        bValid = 1'b0; bData = '0; bFlush = 1'b0; bWe = 1'b0; bAddr = '0; bCoef = '0;
        if (!sel) begin
            aValid = valid; aData = 8'(data); aFlush = flush;
            aWe = we; aAddr = 2'(addr); aCoef = 16'(coef);
        end else begin
            bValid = valid; bData = 8'(data); bFlush = flush;
            bWe = we; bAddr = 5'(addr); bCoef = 16'(coef);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic loadCoef(input bit sel, input int addr, input int coef);
        applyStimulus(sel, 1'b0, 0, 1'b0, 1'b1, addr, coef);
    endtask

    task automatic idle(input bit sel);
        applyStimulus(sel, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Per-cycle vectors for instance A with h = {1,2,3,4}:
        // impulse stream, then the same impulse with valid every 3rd cycle,
        // then a short signed pair.
        tbl[0]  = '{1'b1,  1, 1'b0,  0};  tbl[1]  = '{1'b1,  0, 1'b0,  0};
        tbl[2]  = '{1'b1,  0, 1'b0,  0};  tbl[3]  = '{1'b1,  0, 1'b1,  1};
        tbl[4]  = '{1'b1,  0, 1'b1,  2};  tbl[5]  = '{1'b0,  0, 1'b1,  3};
        tbl[6]  = '{1'b0,  0, 1'b1,  4};  tbl[7]  = '{1'b0,  0, 1'b1,  0};
        tbl[8]  = '{1'b0,  0, 1'b0,  0};  tbl[9]  = '{1'b1,  1, 1'b0,  0};
        tbl[10] = '{1'b0,  0, 1'b0,  0};  tbl[11] = '{1'b0,  0, 1'b0,  0};
        tbl[12] = '{1'b1,  0, 1'b1,  1};  tbl[13] = '{1'b0,  0, 1'b0,  1};
        tbl[14] = '{1'b0,  0, 1'b0,  1};  tbl[15] = '{1'b1,  0, 1'b1,  2};
        tbl[16] = '{1'b0,  0, 1'b0,  2};  tbl[17] = '{1'b0,  0, 1'b0,  2};
        tbl[18] = '{1'b1,  0, 1'b1,  3};  tbl[19] = '{1'b0,  0, 1'b0,  3};
        tbl[20] = '{1'b0,  0, 1'b0,  3};  tbl[21] = '{1'b1,  0, 1'b1,  4};
        tbl[22] = '{1'b0,  0, 1'b0,  4};  tbl[23] = '{1'b0,  0, 1'b0,  4};
        tbl[24] = '{1'b0,  0, 1'b1,  0};  tbl[25] = '{1'b0,  0, 1'b0,  0};
        tbl[26] = '{1'b1, -2, 1'b0,  0};  tbl[27] = '{1'b1,  3, 1'b0,  0};
        tbl[28] = '{1'b0,  0, 1'b0,  0};  tbl[29] = '{1'b0,  0, 1'b1, -2};
        tbl[30] = '{1'b0,  0, 1'b1, -1};  tbl[31] = '{1'b0,  0, 1'b0, -1};

        rst = 1'b1;
        aValid = 1'b0; aData = '0; aFlush = 1'b0; aWe = 1'b0; aAddr = '0; aCoef = '0;
        bValid = 1'b0; bData = '0; bFlush = 1'b0; bWe = 1'b0; bAddr = '0; bCoef = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_a_valid", aValidO, 0);
        checkOutput("reset_a_data", aOut, 0);
        checkOutput("reset_b_valid", bValidO, 0);
        checkOutput("reset_b_data", bOut, 0);
        @(negedge clk);
        rst = 1'b0;

        // Impulse / gapped / signed vectors on A.
        for (int i = 0; i < 4; i++) loadCoef(1'b0, i, i + 1);
        for (int n = 0; n < 32; n++) begin
            applyStimulus(1'b0, tbl[n].valid, tbl[n].data, 1'b0, 1'b0, 0, 0);
            checkOutput($sformatf("tbl_valid[%0d]", n), aValidO, tbl[n].expValid);
            checkOutput($sformatf("tbl_data[%0d]", n), aOut, tbl[n].expData);
        end

        // Rounding on B: h[0] = 0.5, plus a write to an out-of-range address.
        loadCoef(1'b1, 20, 16'h4000);
        loadCoef(1'b1, 0, 16'h2000);
        applyStimulus(1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b1, -3, 1'b0, 1'b0, 0, 0);
        idle(1'b1);
        checkOutput("round_early_valid", bValidO, 0);
        idle(1'b1);
        checkOutput("round_pos_valid", bValidO, 1);
        checkOutput("round_pos_data", bOut, 2);
        idle(1'b1);
        checkOutput("round_neg_valid", bValidO, 1);
        checkOutput("round_neg_data", bOut, -1);
        idle(1'b1);
        checkOutput("round_hold_valid", bValidO, 0);
        checkOutput("round_hold_data", bOut, -1);
`ifdef FIR_SATURATE_EN
        checkOutput("sat_clear", bSat, 0);
`endif

        // Overflow on B: all taps 1.0, seventeen samples of 127 -> 2159.
        for (int i = 0; i < 17; i++) loadCoef(1'b1, i, 16'h4000);
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 127, 1'b0, 1'b0, 0, 0);
        repeat (3) idle(1'b1);
        checkOutput("ovf_valid", bValidO, 1);
`ifdef FIR_SATURATE_EN
        checkOutput("ovf_data", bOut, 127);
        checkOutput("ovf_sat", bSat, 1);
`else
        checkOutput("ovf_data", bOut, 111);
`endif

        // Flush + coefficient write on B. h[0]=0.5, other taps 1/16, line full of 10.
        loadCoef(1'b1, 0, 16'h2000);
        for (int i = 1; i < 17; i++) loadCoef(1'b1, i, 16'h0400);
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 10, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b1, 5, 1'b1, 1'b1, 0, 16'h4000);
        idle(1'b1);
        idle(1'b1);
        checkOutput("flush_inflight_valid", bValidO, 1);
        checkOutput("flush_inflight_data", bOut, 15);
        idle(1'b1);
        checkOutput("flush_new_valid", bValidO, 1);
        checkOutput("flush_new_data", bOut, 5);
        idle(1'b1);
        checkOutput("flush_hold_valid", bValidO, 0);
        checkOutput("flush_hold_data", bOut, 5);

        // Reset mid-stream on A. Line {3,-2,0,0}; sample 7 gives 7, with a second sample in flight.
        applyStimulus(1'b0, 1'b1, 7, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0, 0, 0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("pre_rst_valid", aValidO, 1);
        checkOutput("pre_rst_data", aOut, 7);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_a_valid", aValidO, 0);
        checkOutput("async_rst_a_data", aOut, 0);
        checkOutput("async_rst_b_valid", bValidO, 0);
        checkOutput("async_rst_b_data", bOut, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            checkOutput($sformatf("post_rst_quiet[%0d]", i), aValidO, 0);
        end
        loadCoef(1'b0, 0, 1);
        applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0, 0, 0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("post_rst_latency_valid", aValidO, 0);
        idle(1'b0);
        checkOutput("post_rst_new_valid", aValidO, 1);
        checkOutput("post_rst_new_data", aOut, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
